// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: applies one single-bit shift per clock
// to a 16-bit accumulator, with a start/busy/done handshake.
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [2:0]  op,
  input  logic [3:0]  cnt,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] acc;
  logic [3:0]  rem;
  logic [2:0]  opq;
  logic        accept;
  logic        op_invalid;

  function automatic logic [15:0] shift1(input logic [15:0] a, input logic [2:0] o);
    case (o)
      3'b000:  shift1 = {a[14:0], a[15]};
      3'b001:  shift1 = {a[0], a[15:1]};
      3'b010:  shift1 = {a[14:0], 1'b0};
      3'b011:  shift1 = {a[15], a[15:1]};
      3'b100:  shift1 = {1'b0, a[15:1]};
      default: shift1 = a;
    endcase
  endfunction

  assign accept     = (state == IDLE) && start;
  assign op_invalid = (op >= 3'b101);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (op_invalid || cnt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers; SHIFT is only entered with rem >= 1, so rem never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      rem <= '0;
      opq <= '0;
      err <= 1'b0;
    end else if (accept) begin
      acc <= in;
      opq <= op;
      rem <= cnt;
      err <= op_invalid;
    end else if (state == SHIFT) begin
      acc <= shift1(acc, opq);
      rem <= rem - 4'd1;
    end
  end

  assign result = acc;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq with hand-computed expectations.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_d = '0;
  logic [2:0]  op_d = '0;
  logic [3:0]  cnt_d = '0;
  logic [15:0] result;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in_d),
    .op     (op_d),
    .cnt    (cnt_d),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, wait for done, check latency/result/err, then the
  // cycle after done must be idle with the result held.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [2:0] o,
                        input logic [3:0] c, input int lat, input logic [15:0] exp_res,
                        input logic exp_err);
    int k;
    in_d = a; op_d = o; cnt_d = c; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int dcount;
    int k;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Main operations; done is seen N edges after the accept edge
    run_op("sll4", 16'h0001, 3'b010, 4'd4, 4, 16'h0010, 1'b0);
    run_op("rol1", 16'h8001, 3'b000, 4'd1, 1, 16'h0003, 1'b0);
    run_op("ror4", 16'h1234, 3'b001, 4'd4, 4, 16'h4123, 1'b0);
    run_op("sra15", 16'h8000, 3'b011, 4'd15, 15, 16'hFFFF, 1'b0);
    run_op("srl15", 16'h8000, 3'b100, 4'd15, 15, 16'h0001, 1'b0);

    // Boundaries
    run_op("cnt0", 16'hABCD, 3'b010, 4'd0, 0, 16'hABCD, 1'b0);
    run_op("inval", 16'h5555, 3'b101, 4'd7, 0, 16'h5555, 1'b1);
    run_op("errclr", 16'h00F0, 3'b100, 4'd4, 4, 16'h000F, 1'b0);

    // Start held high: accepted every cnt+2 = 4 cycles
    in_d = 16'h0001; op_d = 3'b010; cnt_d = 4'd2; start = 1'b1;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) begin
        check("cont_done_cycle", c, 2 + 4 * dcount);
        check("cont_result", 32'(result), 32'h0004);
        dcount++;
      end
      if (c == 11) start = 1'b0;
    end
    check("cont_done_count", dcount, 3);
    tick();
    tick();
    check("cont_idle", 32'(busy), 32'd0);

    // Start pulsed during SHIFT must be ignored and not queued
    in_d = 16'h0001; op_d = 3'b010; cnt_d = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_d = 16'hFFFF; op_d = 3'b000; cnt_d = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 2;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check("ign_latency", k, 6);
    check("ign_result", 32'(result), 32'h0040);
    tick();
    check("ign_busy1", 32'(busy), 32'd0);
    tick();
    check("ign_busy2", 32'(busy), 32'd0);
    check("ign_hold", 32'(result), 32'h0040);

    // Reset in the middle of a cnt=10 shift
    in_d = 16'h0001; op_d = 3'b010; cnt_d = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_result", 32'(result), 32'h0);
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) dcount++;
    end
    check("mid_no_done", dcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
